fifo_reader: RTL

Read-side controller for the team's synchronous FIFO. It watches the FIFO's empty flag, issues read enables, and captures the FIFO's registered data_out one cycle later into a 2-entry skid buffer. It presents the captured words downstream as a valid/ready stream, so a stalling consumer never loses data and never causes a FIFO underflow. It sits between the FIFO DUT read port and any downstream consumer.

---
 rtl/fifo_reader_if.sv | 27 ++
 rtl/fifo_reader.sv | 125 ++++++++++++
 2 files changed

// File: rtl/fifo_reader_if.sv
// Bundle of the FIFO read port and the downstream valid/ready stream seen by fifo_reader.
// master = the reader itself, slave = the FIFO plus consumer side.
interface fifo_reader_if #(
  parameter int unsigned FIFO_WIDTH  = 16,
  parameter int unsigned COUNT_WIDTH = 16
);
  logic                   fifo_rd_en;
  logic [FIFO_WIDTH-1:0]  fifo_data_out;
  logic                   fifo_empty;
  logic                   fifo_almostempty;
  logic                   fifo_underflow;
  logic [FIFO_WIDTH-1:0]  m_data;
  logic                   m_valid;
  logic                   m_ready;
  logic [COUNT_WIDTH-1:0] rd_count;
  logic                   underflow_err;

  modport master (
    output fifo_rd_en, m_data, m_valid, rd_count, underflow_err,
    input  fifo_data_out, fifo_empty, fifo_almostempty, fifo_underflow, m_ready
  );

  modport slave (
    input  fifo_rd_en, m_data, m_valid, rd_count, underflow_err,
    output fifo_data_out, fifo_empty, fifo_almostempty, fifo_underflow, m_ready
  );
endinterface

// File: rtl/fifo_reader.sv
// Read-side controller for the synchronous FIFO: issues reads, captures data into a 2-entry skid
// buffer and presents it as a valid/ready stream. Statistics built only with FIFO_READER_STATS_EN.
module fifo_reader #(
  parameter int unsigned FIFO_WIDTH  = 16,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input logic           clk,
  input logic           rst_n,
  fifo_reader_if.master bus
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  pend_q, pend_d;
  logic                  m_valid_q, m_valid_d;
  logic [FIFO_WIDTH-1:0] head_q, head_d;
  logic [FIFO_WIDTH-1:0] tail_q, tail_d;

  logic       pop_c;
  logic       cap_c;
  logic       rd_en_c;
  logic [2:0] level_c;
  logic       unused_c;

  // almost-empty is informational only; reads are gated purely on empty.
  assign unused_c = bus.fifo_almostempty;

  assign pop_c = m_valid_q & bus.m_ready;
  assign cap_c = pend_q & ~bus.fifo_underflow;

  // Entries held plus the word in flight, after this cycle's pop; a read may not make it exceed 2.
  assign level_c = 3'(state_q) + 3'(pend_q) - 3'(pop_c);
  assign rd_en_c = rst_n & ~bus.fifo_empty & (level_c < 3'd2);

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    pend_d  = rd_en_c;
    case (state_q)
      ST_EMPTY: begin
        if (cap_c) begin
          head_d  = bus.fifo_data_out;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (pop_c && cap_c) begin
          head_d = bus.fifo_data_out;
        end else if (pop_c) begin
          state_d = ST_EMPTY;
        end else if (cap_c) begin
          tail_d  = bus.fifo_data_out;
          state_d = ST_TWO;
        end
      end
      ST_TWO: begin
        // A capture without a pop cannot happen here: the read gate keeps held + in-flight <= 2.
        if (pop_c) begin
          head_d = tail_q;
          if (cap_c) begin
            tail_d = bus.fifo_data_out;
          end else begin
            state_d = ST_ONE;
          end
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    m_valid_d = (state_d != ST_EMPTY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_EMPTY;
      pend_q    <= 1'b0;
      m_valid_q <= 1'b0;
      head_q    <= '0;
      tail_q    <= '0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      m_valid_q <= m_valid_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
    end
  end

  assign bus.fifo_rd_en = rd_en_c;
  assign bus.m_data     = head_q;
  assign bus.m_valid    = m_valid_q;

`ifdef FIFO_READER_STATS_EN
  logic [COUNT_WIDTH-1:0] rd_count_q, rd_count_d;
  logic                   uf_err_q, uf_err_d;

  // Delivered-word counter (wraps) and sticky underflow flag.
  always_comb begin
    rd_count_d = rd_count_q + COUNT_WIDTH'(pop_c);
    uf_err_d   = uf_err_q | bus.fifo_underflow;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count_q <= '0;
      uf_err_q   <= 1'b0;
    end else begin
      rd_count_q <= rd_count_d;
      uf_err_q   <= uf_err_d;
    end
  end

  assign bus.rd_count      = rd_count_q;
  assign bus.underflow_err = uf_err_q;
`else
  assign bus.rd_count      = '0;
  assign bus.underflow_err = 1'b0;
`endif

endmodule
